blink_scheduler: RTL
====================

Name: blink_scheduler

Overview:
- Shares the single board LED between N_REQ requesters.
- Each requester asks for a burst of N blinks.
- Round-robin arbitration picks one request; an FSM plays its blink burst and then a quiet gap.
- Timing comes from an internal tick prescaler clocked from the 100 MHz system clock.
- Sits between user logic (buttons, status sources) and the LED pin.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 1000: timer tick rate. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- N_REQ, 4: number of requesters, 2..8.
- CNT_W, 4: width of each blink-count field.
- ON_TICKS, 250: LED-on duration per blink, in ticks.
- OFF_TICKS, 250: LED-off duration after each blink, in ticks.
- GAP_TICKS, 1000: quiet time after a burst before release, in ticks.

Ports:
- i_clk, in, 1: system clock, single domain.
- reset, in, 1: asynchronous, active-high reset.
- req, in, N_REQ: request per requester. Hold high until done.
- blink_cnt, in, N_REQ*CNT_W: blink count for requester i, at bits [i*CNT_W +: CNT_W]. Sampled at grant.
- gnt, out, N_REQ: one-hot grant, held for the whole burst.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse when a burst finishes.
- led, out, 1: LED drive.

Behaviour:
- Reset (async assert):
  - state = IDLE.
  - gnt = 0, busy = 0, done = 0, led = 0.
  - Prescaler = 0, tick timer = 0, remaining = 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
- Prescaler:
  - Counts 0..DIV-1 and emits tick on DIV-1.
  - Prescaler and tick timer both clear on every state entry, so each phase lasts exactly X_TICKS*DIV cycles.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any req is high, grant the first set bit searching from pointer+1 with wrap-around.
  - On the next edge: gnt[k] = 1, pointer = k, remaining = blink_cnt[k].
  - If the count is nonzero: state = ON, led = 1.
  - If the count is 0: state = GAP, led = 0 (no blinks, gap still enforced).
- ON: after ON_TICKS ticks go to OFF with led = 0, and decrement remaining.
- OFF: after OFF_TICKS ticks:
  - remaining ≠ 0: go to ON.
  - remaining = 0: go to GAP.
- GAP: after GAP_TICKS ticks, on one edge:
  - state = IDLE, gnt = 0, done = 1 for one cycle.
  - The pointer keeps k, so k has lowest priority next.
- Back-to-back: arbitration runs in the done cycle, so the next gnt can rise on the following edge.
- Burst length: from gnt rise to done is n*(ON_TICKS+OFF_TICKS)*DIV + GAP_TICKS*DIV cycles.
- Abort: if req[k] drops while in ON or OFF, go to GAP on the next edge with led = 0. done still pulses at gap end.
- req[k] dropping during GAP has no effect.
- Requests arriving while busy wait; nothing is queued beyond the req level.
- blink_cnt changes after grant are ignored.
- Reset mid-burst: immediate return to reset values. done does not pulse.
- Width rules:
  - remaining is CNT_W bits and only decremented while nonzero.
  - Tick timer width is clog2 of max(ON_TICKS, OFF_TICKS, GAP_TICKS)+1.

Optional Feature:
- Macro BLINK_SCHED_HEARTBEAT_EN.
- Defined:
  - In IDLE, led toggles every TICK_HZ/2 ticks, giving a 1 Hz heartbeat.
  - The heartbeat counter and phase reset to 0 on every IDLE entry.
  - led is forced to 0 on the grant edge.
- Undefined: led = 0 throughout IDLE, and no heartbeat logic is present.

Decomposition:
- Package blink_sched_pkg holds:
  - State enum typedef: IDLE, ON, OFF, GAP.
  - DIV derivation and the timer-width constant function.
- One sub-module, blink_tick_gen: prescaler with synchronous clear input and tick output. Parameters CLK_HZ and TICK_HZ.
- Round-robin pick stays inline.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1000, TICK_HZ=100 (DIV=10), ON=2, OFF=3, GAP=4, N_REQ=4, CNT_W=4.
- Single burst: req[0]=1 with count 2 in IDLE.
  - gnt=0001 on the next edge.
  - led high for 20 cycles, low 30, high 20, then low through the GAP.
  - done pulses 140 cycles after gnt rises; gnt=0 in that same cycle.
- Round-robin:
  - req=1111 held, all counts 1.
  - Grant order is 0,1,2,3,0.
  - Each gnt rises exactly 1 cycle after the previous done.
- Zero count: req[2]=1 with count 0.
  - gnt=0100, led stays 0.
  - done pulses 40 cycles after grant.
- Abort: req[1] with count 5 is dropped 25 cycles after grant (in the first OFF phase).
  - GAP is entered on the next edge.
  - done pulses 40 cycles later.
- Async reset asserted mid-ON: gnt, led, busy and done all go to 0 immediately without waiting for a clock edge; no done pulse follows.
- Heartbeat, with BLINK_SCHED_HEARTBEAT_EN defined and no requests: led toggles every 500 cycles (50 ticks × DIV 10).

Source files
------------

// File: rtl/blink_sched_pkg.sv
// Shared types and elaboration-time helpers for the LED blink scheduler.
package blink_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Tick timer must hold the longest phase length.
  function automatic int unsigned timer_width(input int unsigned on_t,
                                              input int unsigned off_t,
                                              input int unsigned gap_t);
    int unsigned m;
    m = on_t;
    if (off_t > m) m = off_t;
    if (gap_t > m) m = gap_t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Tick prescaler: counts 0..DIV-1 and flags the terminal count; clr restarts it.
module blink_tick_gen
  import blink_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic i_clk,
  input  logic reset,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned DIV_W = $clog2(DIV);

  logic [DIV_W-1:0] cnt;

  assign tick_c = (cnt == DIV_W'(DIV - 1));

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/blink_scheduler.sv
// Round-robin owner of the board LED: plays an N-blink burst per granted request, then a quiet gap.
// Define BLINK_SCHED_HEARTBEAT_EN to blink a 1 Hz heartbeat while idle.
module blink_scheduler
  import blink_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned ON_TICKS  = 250,
  parameter int unsigned OFF_TICKS = 250,
  parameter int unsigned GAP_TICKS = 1000
) (
  input  logic                   i_clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] blink_cnt,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   led
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned TMR_W = timer_width(ON_TICKS, OFF_TICKS, GAP_TICKS);

  blink_state_e     state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] remaining;
  logic [TMR_W-1:0] timer;

  logic             tick_c;
  logic             clr_c;
  logic             pick_valid_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic [CNT_W-1:0] pick_cnt_c;
  logic             grant_c;
  logic             abort_c;
  logic             phase_end_c;
  logic [TMR_W-1:0] phase_lim_c;

  logic [CNT_W-1:0] cnt_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign cnt_arr[g] = blink_cnt[g*CNT_W +: CNT_W];
  end

  blink_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .i_clk  (i_clk),
    .reset  (reset),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_valid_c = 1'b0;
    pick_idx_c   = ptr;
    for (int unsigned o = 1; o <= N_REQ; o++) begin
      if (!pick_valid_c && req[IDX_W'((32'(ptr) + o) % N_REQ)]) begin
        pick_valid_c = 1'b1;
        pick_idx_c   = IDX_W'((32'(ptr) + o) % N_REQ);
      end
    end
  end

  assign pick_cnt_c = cnt_arr[pick_idx_c];

  always_comb begin
    phase_lim_c = TMR_W'(ON_TICKS);
    case (state)
      OFF:     phase_lim_c = TMR_W'(OFF_TICKS);
      GAP:     phase_lim_c = TMR_W'(GAP_TICKS);
      default: phase_lim_c = TMR_W'(ON_TICKS);
    endcase
  end

  assign grant_c     = (state == IDLE) && pick_valid_c;
  assign abort_c     = ((state == ON) || (state == OFF)) && !req[ptr];
  assign phase_end_c = (state != IDLE) && tick_c && (timer == phase_lim_c - TMR_W'(1));
  // Every state entry restarts prescaler and timer so phases are exact multiples of DIV.
  assign clr_c       = grant_c || abort_c || phase_end_c;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (clr_c) begin
      timer <= '0;
    end else if (tick_c && (state != IDLE)) begin
      timer <= timer + TMR_W'(1);
    end
  end

`ifdef BLINK_SCHED_HEARTBEAT_EN
  localparam int unsigned HB_TICKS = TICK_HZ / 2;
  localparam int unsigned HB_W     = $clog2(HB_TICKS + 1);

  logic [HB_W-1:0] hb_cnt;
  logic            hb_toggle_c;

  assign hb_toggle_c = (state == IDLE) && tick_c && (hb_cnt == HB_W'(HB_TICKS - 1));

  // Held at zero outside IDLE so every idle period starts a fresh heartbeat.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      hb_cnt <= '0;
    end else if ((state != IDLE) || grant_c || hb_toggle_c) begin
      hb_cnt <= '0;
    end else if (tick_c) begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end
`endif

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      led       <= 1'b0;
      ptr       <= IDX_W'(N_REQ - 1);
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            gnt       <= N_REQ'(1) << pick_idx_c;
            ptr       <= pick_idx_c;
            remaining <= pick_cnt_c;
            busy      <= 1'b1;
            if (pick_cnt_c != '0) begin
              state <= ON;
              led   <= 1'b1;
            end else begin
              state <= GAP;
              led   <= 1'b0;
            end
          end
`ifdef BLINK_SCHED_HEARTBEAT_EN
          else if (hb_toggle_c) begin
            led <= ~led;
          end
`endif
        end
        ON: begin
          if (abort_c) begin
            state <= GAP;
            led   <= 1'b0;
          end else if (phase_end_c) begin
            state <= OFF;
            led   <= 1'b0;
            if (remaining != '0) remaining <= remaining - CNT_W'(1);
          end
        end
        OFF: begin
          if (abort_c) begin
            state <= GAP;
            led   <= 1'b0;
          end else if (phase_end_c) begin
            if (remaining != '0) begin
              state <= ON;
              led   <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (phase_end_c) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            led   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
